// File: rtl/channel_pkg.sv
// Shared widths, pipeline tag type and the sine-table generator for the
// single-channel lock-in (I/Q) amplitude detector.
package channel_pkg;

    localparam int AXIS_TDATA_WIDTH = 24;
    localparam int PHASE_WIDTH      = 15;
    localparam int SAMPLE_WIDTH     = 17;
    localparam int LUT_ADDR_WIDTH   = 10;
    localparam int LUT_WIDTH        = 16;
    localparam int ACC_LOG2         = 10;

    // 33-bit product >>> 15 leaves 18 significant bits; 2^ACC_LOG2 of them fit in 28.
    localparam int PROD_WIDTH = 18;
    localparam int ACC_WIDTH  = PROD_WIDTH + ACC_LOG2;
    localparam int MULT_WIDTH = SAMPLE_WIDTH + LUT_WIDTH;
    localparam int LUT_DEPTH  = 1 << LUT_ADDR_WIDTH;
    localparam int QUARTER    = LUT_DEPTH / 4;

    localparam real PI = 3.14159265358979323846;

    // Travels alongside each beat through the datapath.
    typedef struct packed {
        logic valid;
        logic first;   // first beat of a block: accumulators load
        logic last;    // Nth beat of a block: accumulators dump
    } beat_tag_t;

    // round(32767 * sin(2*pi*k/LUT_DEPTH)), half away from zero.
    function automatic logic signed [LUT_WIDTH-1:0] sine_entry(input int k);
        real x;
        int  v;
        x = real'((1 << (LUT_WIDTH - 1)) - 1) * $sin(2.0 * PI * real'(k) / real'(LUT_DEPTH));
        if (x >= 0.0) v = $rtoi(x + 0.5);
        else          v = -$rtoi(0.5 - x);
        return LUT_WIDTH'(v);
    endfunction

endpackage

// File: rtl/channel_sincos_rom.sv
// Dual-read registered sine ROM: sin at idx, cos at idx + quarter period.
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_idx            table address
//   o_sin, o_cos     registered table outputs (1-cycle latency)
module channel_sincos_rom
    import channel_pkg::*;
(
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic [LUT_ADDR_WIDTH-1:0]     i_idx,
    output logic signed [LUT_WIDTH-1:0]   o_sin,
    output logic signed [LUT_WIDTH-1:0]   o_cos
);

    logic signed [LUT_WIDTH-1:0]  w_table [LUT_DEPTH];
    logic [LUT_ADDR_WIDTH-1:0]    w_cos_idx;
    logic signed [LUT_WIDTH-1:0]  r_sin;
    logic signed [LUT_WIDTH-1:0]  r_cos;

    for (genvar k = 0; k < LUT_DEPTH; k++) begin : g_table
        assign w_table[k] = sine_entry(k);
    end

    // Natural wrap of the address adder gives the mod-LUT_DEPTH offset.
    assign w_cos_idx = i_idx + LUT_ADDR_WIDTH'(QUARTER);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sin <= '0;
            r_cos <= '0;
        end else begin
            r_sin <= w_table[i_idx];
            r_cos <= w_table[w_cos_idx];
        end
    end

    assign o_sin = r_sin;
    assign o_cos = r_cos;

endmodule

// File: rtl/channel.sv
// Single-channel lock-in amplitude detector. Each accepted beat pairs a
// phase word with an ADC sample; the sample is mixed with sin/cos of the
// phase, I/Q are accumulated over 2^ACC_LOG2 beats, and one magnitude
// estimate (max + min/4, scaled by 1/N) is emitted per block.
// Ports:
//   aclk, aresetn                   clock, asynchronous active-low reset
//   phase_tdata/tvalid/tready       reference phase stream
//   samples_tdata/tvalid/tready     signed sample stream
//   magnitude_tdata/tvalid          one-cycle result pulse per block
module channel
    import channel_pkg::*;
(
    input  logic                          aclk,
    input  logic                          aresetn,
    input  logic [AXIS_TDATA_WIDTH-1:0]   phase_tdata,
    input  logic                          phase_tvalid,
    output logic                          phase_tready,
    input  logic [AXIS_TDATA_WIDTH-1:0]   samples_tdata,
    input  logic                          samples_tvalid,
    output logic                          samples_tready,
    output logic [AXIS_TDATA_WIDTH-1:0]   magnitude_tdata,
    output logic                          magnitude_tvalid
);

    logic                           r_ready;
    logic                           w_accept;
    logic [ACC_LOG2-1:0]            r_cnt;

    logic [LUT_ADDR_WIDTH-1:0]      r_idx0;
    logic signed [SAMPLE_WIDTH-1:0] r_s0;
    logic signed [SAMPLE_WIDTH-1:0] r_s1;
    beat_tag_t                      r_tag0, r_tag1, r_tag2;

    logic signed [LUT_WIDTH-1:0]    w_sin, w_cos;
    logic signed [MULT_WIDTH-1:0]   w_prod_i, w_prod_q;
    logic signed [PROD_WIDTH-1:0]   r_p_i, r_p_q;

    logic signed [ACC_WIDTH-1:0]    w_base_i, w_base_q, w_sum_i, w_sum_q;
    logic signed [ACC_WIDTH-1:0]    r_acc_i, r_acc_q, r_dump_i, r_dump_q;
    logic                           r_dump_v;

    logic [ACC_WIDTH-1:0]           r_abs_i, r_abs_q, w_max, w_min;
    logic                           r_abs_v;
    logic [ACC_WIDTH:0]             w_mag;
    logic [AXIS_TDATA_WIDTH-1:0]    r_mag;
    logic                           r_mag_v;

    logic                           w_unused;

    // Both streams must present a beat together; a lone valid is dropped.
    assign w_accept = phase_tvalid & samples_tvalid & r_ready;

    // Accept edge: capture table index, sample and block-position tag.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_ready <= 1'b0;
            r_cnt   <= '0;
            r_idx0  <= '0;
            r_s0    <= '0;
            r_tag0  <= '0;
        end else begin
            r_ready      <= 1'b1;
            r_tag0.valid <= w_accept;
            r_tag0.first <= (r_cnt == '0);
            r_tag0.last  <= (r_cnt == '1);
            if (w_accept) begin
                r_cnt  <= r_cnt + 1'b1;
                r_idx0 <= phase_tdata[PHASE_WIDTH-1 -: LUT_ADDR_WIDTH];
                r_s0   <= samples_tdata[SAMPLE_WIDTH-1:0];
            end
        end
    end

    channel_sincos_rom u_rom (
        .i_clk   (aclk),
        .i_rst_n (aresetn),
        .i_idx   (r_idx0),
        .o_sin   (w_sin),
        .o_cos   (w_cos)
    );

    assign w_prod_i = MULT_WIDTH'(r_s1) * MULT_WIDTH'(w_sin);
    assign w_prod_q = MULT_WIDTH'(r_s1) * MULT_WIDTH'(w_cos);

    assign w_base_i = r_tag2.first ? '0 : r_acc_i;
    assign w_base_q = r_tag2.first ? '0 : r_acc_q;
    assign w_sum_i  = w_base_i + ACC_WIDTH'(r_p_i);
    assign w_sum_q  = w_base_q + ACC_WIDTH'(r_p_q);

    // Alpha-max-plus-beta-min magnitude with alpha = 1, beta = 1/4.
    assign w_max = (r_abs_i >= r_abs_q) ? r_abs_i : r_abs_q;
    assign w_min = (r_abs_i >= r_abs_q) ? r_abs_q : r_abs_i;
    assign w_mag = {1'b0, w_max} + {3'b000, w_min[ACC_WIDTH-1:2]};

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_s1     <= '0;
            r_tag1   <= '0;
            r_tag2   <= '0;
            r_p_i    <= '0;
            r_p_q    <= '0;
            r_acc_i  <= '0;
            r_acc_q  <= '0;
            r_dump_i <= '0;
            r_dump_q <= '0;
            r_dump_v <= 1'b0;
            r_abs_i  <= '0;
            r_abs_q  <= '0;
            r_abs_v  <= 1'b0;
            r_mag    <= '0;
            r_mag_v  <= 1'b0;
        end else begin
            // E+1: sample delayed to line up with the registered ROM output
            r_s1   <= r_s0;
            r_tag1 <= r_tag0;
            // E+2: products arithmetic-shifted right by 15
            r_tag2 <= r_tag1;
            r_p_i  <= w_prod_i[MULT_WIDTH-1 -: PROD_WIDTH];
            r_p_q  <= w_prod_q[MULT_WIDTH-1 -: PROD_WIDTH];
            // E+3: accumulate; the final sum of a block goes straight to the dump
            if (r_tag2.valid) begin
                r_acc_i <= w_sum_i;
                r_acc_q <= w_sum_q;
                if (r_tag2.last) begin
                    r_dump_i <= w_sum_i;
                    r_dump_q <= w_sum_q;
                end
            end
            r_dump_v <= r_tag2.valid & r_tag2.last;
            // E+4: absolute values
            r_abs_v <= r_dump_v;
            if (r_dump_v) begin
                r_abs_i <= r_dump_i[ACC_WIDTH-1] ? -r_dump_i : r_dump_i;
                r_abs_q <= r_dump_q[ACC_WIDTH-1] ? -r_dump_q : r_dump_q;
            end
            // E+5: scaled magnitude, held until the next block
            r_mag_v <= r_abs_v;
            if (r_abs_v) begin
                r_mag <= AXIS_TDATA_WIDTH'(w_mag >> ACC_LOG2);
            end
        end
    end

    assign phase_tready     = r_ready;
    assign samples_tready   = r_ready;
    assign magnitude_tdata  = r_mag;
    assign magnitude_tvalid = r_mag_v;

    assign w_unused = ^{phase_tdata[AXIS_TDATA_WIDTH-1:PHASE_WIDTH],
                        phase_tdata[PHASE_WIDTH-LUT_ADDR_WIDTH-1:0],
                        samples_tdata[AXIS_TDATA_WIDTH-1:SAMPLE_WIDTH],
                        w_prod_i[MULT_WIDTH-PROD_WIDTH-1:0],
                        w_prod_q[MULT_WIDTH-PROD_WIDTH-1:0]};

endmodule

// File: tb/tb_channel.sv
module tb_channel;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic [23:0] phase_tdata;
    logic        phase_tvalid;
    logic        phase_tready;
    logic [23:0] samples_tdata;
    logic        samples_tvalid;
    logic        samples_tready;
    logic [23:0] magnitude_tdata;
    logic        magnitude_tvalid;

    always #5 aclk = ~aclk;

    channel dut (
        .aclk             (aclk),
        .aresetn          (aresetn),
        .phase_tdata      (phase_tdata),
        .phase_tvalid     (phase_tvalid),
        .phase_tready     (phase_tready),
        .samples_tdata    (samples_tdata),
        .samples_tvalid   (samples_tvalid),
        .samples_tready   (samples_tready),
        .magnitude_tdata  (magnitude_tdata),
        .magnitude_tvalid (magnitude_tvalid)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_tol(input string name, input longint act, input longint exp, input longint tol);
        tests++;
        if (act < exp - tol || act > exp + tol) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d +/- %0d", name, act, exp, tol);
        end
    endtask

    // ---------------- reference sine table and stimulus helpers -------------
    int lut [1024];

    function automatic int rnd(input real x);
        if (x >= 0.0) return $rtoi(x + 0.5);
        return -$rtoi(0.5 - x);
    endfunction

    function automatic int tone(input int idx, input int amp, input int shift, input bit dc);
        real a;
        if (dc) return amp;
        a = 2.0 * 3.14159265358979323846 * real'((idx + shift) % 1024) / 1024.0;
        return rnd(real'(amp) * $sin(a));
    endfunction

    // Junk in the ignored upper bits of both buses.
    function automatic logic [23:0] mk_phase(input int p);
        logic [14:0] v;
        v = p[14:0];
        return {9'h1A5, v};
    endfunction

    function automatic logic [23:0] mk_sample(input int s);
        logic [16:0] v;
        v = s[16:0];
        return {7'h55, v};
    endfunction

    // ---------------- behavioural model of the block arithmetic ------------
    longint m_i, m_q;
    int     m_cnt;
    int     n_exp;
    int     exp_mag [8];

    task automatic model_beat(input logic [23:0] ph, input logic [23:0] sm);
        int     idx, s;
        longint p_i, p_q, a_i, a_q, mx, mn;
        idx = int'(ph[14:5]);
        s   = int'($signed(sm[16:0]));
        p_i = (longint'(s) * longint'(lut[idx])) >>> 15;
        p_q = (longint'(s) * longint'(lut[(idx + 256) % 1024])) >>> 15;
        if (m_cnt == 0) begin
            m_i = p_i;
            m_q = p_q;
        end else begin
            m_i = m_i + p_i;
            m_q = m_q + p_q;
        end
        m_cnt++;
        if (m_cnt == 1024) begin
            a_i = (m_i < 0) ? -m_i : m_i;
            a_q = (m_q < 0) ? -m_q : m_q;
            mx  = (a_i > a_q) ? a_i : a_q;
            mn  = (a_i > a_q) ? a_q : a_i;
            if (n_exp < 8) exp_mag[n_exp] = int'((mx + (mn >> 2)) >> 10);
            n_exp++;
            m_cnt = 0;
        end
    endtask

    // ---------------- monitor: accept edges and output pulses ---------------
    int cyc = 0;
    bit clr = 1'b0;
    int acc_cnt = 0;
    int acc_cyc [4096];
    int npulse = 0;
    int pulse_cyc [8];
    int pulse_dat [8];

    always @(posedge aclk) begin
        cyc <= cyc + 1;
        if (clr) begin
            acc_cnt <= 0;
        end else if (aresetn && phase_tvalid && samples_tvalid && phase_tready && samples_tready) begin
            if (acc_cnt < 4096) acc_cyc[acc_cnt] <= cyc + 1;
            acc_cnt <= acc_cnt + 1;
        end
    end

    always @(negedge aclk) begin
        if (clr) begin
            npulse <= 0;
        end else if (magnitude_tvalid) begin
            if (npulse < 8) begin
                pulse_cyc[npulse] <= cyc;
                pulse_dat[npulse] <= int'(magnitude_tdata);
            end
            npulse <= npulse + 1;
        end
    end

    task automatic start_test();
        clr   = 1'b1;
        m_cnt = 0;
        n_exp = 0;
        @(posedge aclk);
        @(negedge aclk);
        #1 clr = 1'b0;
        @(posedge aclk);
        #1;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge aclk);
        #1;
    endtask

    // Back-to-back beats; caller is positioned 1 time unit after a rising edge.
    task automatic drive_beats(input int n, input int step, input int off,
                               input int amp, input int shift, input bit dc);
        for (int b = 0; b < n; b++) begin
            int p;
            p              = (off + b * step) & 32'h7FFF;
            phase_tdata    = mk_phase(p);
            samples_tdata  = mk_sample(tone((p >> 5) & 1023, amp, shift, dc));
            phase_tvalid   = 1'b1;
            samples_tvalid = 1'b1;
            model_beat(phase_tdata, samples_tdata);
            @(posedge aclk);
            #1;
        end
        phase_tvalid   = 1'b0;
        samples_tvalid = 1'b0;
    endtask

    // ---------------- directed block vectors --------------------------------
    typedef struct {
        string name;
        int    step;
        int    off;
        int    amp;
        int    shift;
        bit    dc;
        int    exp_mag;
        int    tol;
    } vec_t;

    vec_t vecs [7];
    int   clean_ref;

    initial begin
        vecs[0] = '{"dc",        32'h0020, 0,       -32768, 0,   1'b1, 0,    2};
        vecs[1] = '{"tone_sin",  32'h0020, 0,       16000,  0,   1'b0, 8000, 80};
        vecs[2] = '{"tone_cos",  32'h0020, 0,       16000,  256, 1'b0, 8000, 80};
        vecs[3] = '{"tone_45",   32'h0020, 0,       16000,  128, 1'b0, 7071, 80};
        vecs[4] = '{"tone_off",  32'h0040, 32'h1234, 8000,  0,   1'b0, 4000, 40};
        vecs[5] = '{"tone_negI", 32'h0020, 0,       12000,  512, 1'b0, 6000, 60};
        vecs[6] = '{"tone_negQ", 32'h0020, 0,       12000,  768, 1'b0, 6000, 60};

        for (int k = 0; k < 1024; k++)
            lut[k] = rnd(32767.0 * $sin(2.0 * 3.14159265358979323846 * real'(k) / 1024.0));

        // Reset with both valids high
        aresetn        = 1'b0;
        phase_tdata    = '0;
        samples_tdata  = '0;
        phase_tvalid   = 1'b1;
        samples_tvalid = 1'b1;
        #20;
        check("rst_phase_tready", phase_tready, 0);
        check("rst_samples_tready", samples_tready, 0);
        check("rst_mag_tdata", magnitude_tdata, 0);
        check("rst_mag_tvalid", magnitude_tvalid, 0);
        @(posedge aclk);
        #1;
        aresetn        = 1'b1;
        phase_tvalid   = 1'b0;
        samples_tvalid = 1'b0;
        @(posedge aclk);
        #1;
        check("rel_phase_tready", phase_tready, 1);
        check("rel_samples_tready", samples_tready, 1);

        // Table-driven single blocks
        foreach (vecs[v]) begin
            start_test();
            drive_beats(1024, vecs[v].step, vecs[v].off, vecs[v].amp, vecs[v].shift, vecs[v].dc);
            wait_cycles(12);
            check({vecs[v].name, "_pulses"}, npulse, 1);
            check({vecs[v].name, "_latency"}, pulse_cyc[0] - acc_cyc[1023], 5);
            check({vecs[v].name, "_exact"}, pulse_dat[0], exp_mag[0]);
            check_tol({vecs[v].name, "_nominal"}, pulse_dat[0], vecs[v].exp_mag, vecs[v].tol);
            if (v == 1) clean_ref = exp_mag[0];
        end

        // Two back-to-back blocks: timing of both pulses and no beat lost at the seam
        start_test();
        drive_beats(1024, 32'h0020, 0, 16000, 0, 1'b0);
        drive_beats(1024, 32'h0020, 0, 8000, 64, 1'b0);
        wait_cycles(12);
        check("b2b_accepts", acc_cnt, 2048);
        check("b2b_pulses", npulse, 2);
        check("b2b_seam_gap", acc_cyc[1024] - acc_cyc[1023], 1);
        check("b2b_latency0", pulse_cyc[0] - acc_cyc[1023], 5);
        check("b2b_latency1", pulse_cyc[1] - acc_cyc[2047], 5);
        check("b2b_value0", pulse_dat[0], exp_mag[0]);
        check("b2b_value1", pulse_dat[1], exp_mag[1]);

        // Sparse handshake: samples always valid, phase valid one cycle in 40
        start_test();
        samples_tvalid = 1'b1;
        for (int j = 0; j < 1024; j++) begin
            int p;
            if (j == 1023) check("sparse_no_early_pulse", npulse, 0);
            p             = (j * 32'h0EB8) & 32'h7FFF;
            phase_tdata   = mk_phase(p);
            samples_tdata = mk_sample(tone((p >> 5) & 1023, 16000, 0, 1'b0));
            phase_tvalid  = 1'b1;
            model_beat(phase_tdata, samples_tdata);
            @(posedge aclk);
            #1;
            phase_tvalid = 1'b0;
            for (int g = 0; g < 39; g++) begin
                phase_tdata   = 24'($urandom);
                samples_tdata = 24'($urandom);
                @(posedge aclk);
                #1;
            end
        end
        samples_tvalid = 1'b0;
        wait_cycles(12);
        check("sparse_accepts", acc_cnt, 1024);
        check("sparse_pulses", npulse, 1);
        check("sparse_latency", pulse_cyc[0] - acc_cyc[1023], 5);
        check("sparse_value", pulse_dat[0], exp_mag[0]);

        // Reset in the middle of a block discards the partial block
        start_test();
        drive_beats(500, 32'h0020, 0, 16000, 0, 1'b0);
        aresetn = 1'b0;
        #1;
        check("midrst_tready", phase_tready, 0);
        check("midrst_mag_tdata", magnitude_tdata, 0);
        check("midrst_mag_tvalid", magnitude_tvalid, 0);
        repeat (3) @(posedge aclk);
        #1;
        aresetn = 1'b1;
        begin
            int w;
            w = 0;
            while (!phase_tready && w < 5) begin
                @(posedge aclk);
                #1;
                w++;
            end
        end
        check("midrst_ready_back", phase_tready, 1);
        start_test();
        drive_beats(1024, 32'h0020, 0, 16000, 0, 1'b0);
        wait_cycles(12);
        check("midrst_pulses", npulse, 1);
        check("midrst_latency", pulse_cyc[0] - acc_cyc[1023], 5);
        check("midrst_value_clean", pulse_dat[0], clean_ref);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

endmodule
